// File: rtl/alu_pkg.sv
// Shared encodings and widths for the two-requester ALU arbiter.
package alu_pkg;

  localparam int DATA_W  = 4;
  localparam int SHAMT_W = 2;

  typedef enum logic [1:0] {
    OP_SRA = 2'b00,
    OP_SRL = 2'b01,
    OP_SUB = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter: a sole requester wins, a tie goes to the requester
// named by ptr. Purely combinational; the owner keeps ptr.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // One-hot grant from the request vector and the priority pointer
  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a 4-bit shift/add/sub ALU.
// One operation in flight: IDLE (grant) -> EXEC (compute) -> RESP (hold).
// Optional feature: define ALU_ARB_FLAGS_EN to add registered rsp_zero and
// rsp_carry outputs.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [1:0]         req0_op,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [SHAMT_W-1:0] req0_c,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [1:0]         req1_op,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [SHAMT_W-1:0] req1_c,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_data,
`ifdef ALU_ARB_FLAGS_EN
  output logic               rsp_zero,
  output logic               rsp_carry,
`endif
  output logic               busy
);

  state_e             state_q, state_d;
  logic               ptr_q;
  logic [1:0]         grant;
  logic [1:0]         req_ready;
  op_e                op_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [SHAMT_W-1:0] c_q;
  logic               rsp_id_q;
  logic [DATA_W-1:0]  rsp_data_q;

  function automatic logic [DATA_W-1:0] alu_f(op_e op, logic [DATA_W-1:0] a,
                                              logic [DATA_W-1:0] b,
                                              logic [SHAMT_W-1:0] c);
    logic signed [DATA_W-1:0] sa;
    logic [DATA_W-1:0]        r;
    sa = a;
    unique case (op)
      OP_SRA:  r = sa >>> c;
      OP_SRL:  r = a >> c;
      OP_SUB:  r = a - b;
      default: r = a + b;
    endcase
    return r;
  endfunction

`ifdef ALU_ARB_FLAGS_EN
  // Carry-out for add, borrow for sub, nothing for shifts.
  function automatic logic carry_f(op_e op, logic [DATA_W-1:0] a,
                                   logic [DATA_W-1:0] b);
    logic cy;
    unique case (op)
      OP_SUB:  cy = (a < b);
      OP_ADD:  cy = (({1'b0, a} + {1'b0, b}) > 5'd15);
      default: cy = 1'b0;
    endcase
    return cy;
  endfunction
`endif

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Readies only in IDLE and never while reset is asserted.
  assign req_ready  = (state_q == ST_IDLE && !reset) ? grant : 2'b00;
  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp_valid  = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;

  // Next-state logic for the single-issue sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (|req_ready) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, priority pointer and response id; pointer moves to the loser
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= RR_INIT;
      rsp_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (|req_ready) begin
        ptr_q    <= req_ready[0];
        rsp_id_q <= req_ready[1];
      end
    end
  end

  // Operand capture on grant; no reset needed, consumed only in EXEC
  always_ff @(posedge clk) begin
    if (req_ready[1]) begin
      op_q <= op_e'(req1_op);
      a_q  <= req1_a;
      b_q  <= req1_b;
      c_q  <= req1_c;
    end else if (req_ready[0]) begin
      op_q <= op_e'(req0_op);
      a_q  <= req0_a;
      b_q  <= req0_b;
      c_q  <= req0_c;
    end
  end

  // Result register, loaded in EXEC and held through RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data_q <= '0;
    end else if (state_q == ST_EXEC) begin
      rsp_data_q <= alu_f(op_q, a_q, b_q, c_q);
    end
  end

`ifdef ALU_ARB_FLAGS_EN
  logic rsp_zero_q, rsp_carry_q;

  // Flags registered alongside the result
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_zero_q  <= (alu_f(op_q, a_q, b_q, c_q) == '0);
      rsp_carry_q <= carry_f(op_q, a_q, b_q);
    end
  end

  assign rsp_zero  = rsp_zero_q;
  assign rsp_carry = rsp_carry_q;
`endif

endmodule
